// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
package hazard_pkg;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;
  typedef enum logic {
    RUN     = 1'b0,
    BR_PEND = 1'b1
  } hz_state_e;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding source select for one EX operand, EXMEM over MEMWB.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int W = DEF_REG_ADDR_WIDTH
) (
  input  logic [W-1:0] rs,
  input  logic [W-1:0] exmem_rd,
  input  logic         exmem_we,
  input  logic [W-1:0] memwb_rd,
  input  logic         memwb_we,
  output fwd_sel_e     sel
);
  assign sel = (exmem_we && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
               (memwb_we && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall/redirect/load-use counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] IFID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IFID_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] IDEX_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IDEX_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] IDEX_rd,
  input  logic                      IDEX_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] EXMEM_rd,
  input  logic                      EXMEMRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEMWB_rd,
  input  logic                      MEMWBRegWrite,
  input  logic                      branch_taken,
  input  logic                      if_req,
  input  logic                      if_ack,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  output logic [1:0]                fwd_sel_a,
  output logic [1:0]                fwd_sel_b,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      flush_wb,
  output logic                      pc_redirect
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0]    perf_stall_cnt,
  output logic [CNT_WIDTH-1:0]      perf_flush_cnt,
  output logic [CNT_WIDTH-1:0]      perf_lu_cnt
`endif
);
  fwd_sel_e  sel_a, sel_b;
  hz_state_e state, state_n;
  logic      mem_busy, if_busy, load_use, pend, take_br, lu_hit, if_hold;
  fwd_sel_unit #(.W(REG_ADDR_WIDTH)) u_fwd_a (
    .rs(IDEX_rs1), .exmem_rd(EXMEM_rd), .exmem_we(EXMEMRegWrite),
    .memwb_rd(MEMWB_rd), .memwb_we(MEMWBRegWrite), .sel(sel_a)
  );
  fwd_sel_unit #(.W(REG_ADDR_WIDTH)) u_fwd_b (
    .rs(IDEX_rs2), .exmem_rd(EXMEM_rd), .exmem_we(EXMEMRegWrite),
    .memwb_rd(MEMWB_rd), .memwb_we(MEMWBRegWrite), .sel(sel_b)
  );
  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RUN;
    else       state <= state_n;
  // In BR_PEND, EX holds a bubble, so only the MEM wait and the fetch matter.
  always_comb begin
    mem_busy    = mem_req && !mem_ack;
    if_busy     = if_req && !if_ack;
    load_use    = IDEX_MemRead && IDEX_rd != '0 && (IDEX_rd == IFID_rs1 || IDEX_rd == IFID_rs2);
    pend        = state == BR_PEND;
    take_br     = !pend && !mem_busy && branch_taken;
    lu_hit      = !pend && !mem_busy && !branch_taken && load_use;
    if_hold     = !pend && !mem_busy && !branch_taken && !load_use && if_busy;
    flush_id    = pend || take_br || if_hold;
    flush_ex    = take_br || lu_hit;
    flush_wb    = mem_busy;
    pc_redirect = take_br;
    stall_if    = mem_busy || lu_hit || if_hold || (pend && if_busy);
    stall_id    = (mem_busy || lu_hit) && !flush_id;
    stall_ex    = mem_busy && !flush_ex;
    stall_mem   = mem_busy;
    state_n     = pend ? (if_ack ? RUN : BR_PEND) : ((take_br && if_busy) ? BR_PEND : RUN);
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (stall_if && !(&perf_stall_cnt))    perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (pc_redirect && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (lu_hit && !(&perf_lu_cnt))         perf_lu_cnt    <= perf_lu_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a rule-level model.
// Optionally checks the counters added by HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic idex_mr, exmem_we, memwb_we, br, if_req, if_ack, mem_req, mem_ack;
  logic [1:0] fwd_a, fwd_b;
  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, pcr;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] p_stall, p_flush, p_lu;
`endif
  int vectors = 0, miscompares = 0;
  int m_stall = 0, m_flush = 0, m_lu = 0;
  bit pend_m = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs1(ifid_rs1), .IFID_rs2(ifid_rs2), .IDEX_rs1(idex_rs1), .IDEX_rs2(idex_rs2),
    .IDEX_rd(idex_rd), .IDEX_MemRead(idex_mr), .EXMEM_rd(exmem_rd), .EXMEMRegWrite(exmem_we),
    .MEMWB_rd(memwb_rd), .MEMWBRegWrite(memwb_we), .branch_taken(br),
    .if_req(if_req), .if_ack(if_ack), .mem_req(mem_req), .mem_ack(mem_ack),
    .fwd_sel_a(fwd_a), .fwd_sel_b(fwd_b),
    .stall_if(s_if), .stall_id(s_id), .stall_ex(s_ex), .stall_mem(s_mem),
    .flush_id(f_id), .flush_ex(f_ex), .flush_wb(f_wb), .pc_redirect(pcr)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(p_stall), .perf_flush_cnt(p_flush), .perf_lu_cnt(p_lu)
`endif
  );
  function automatic logic [11:0] obs();
    return {fwd_a, fwd_b, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, pcr};
  endfunction
  function automatic logic [1:0] fwd_of(input logic [4:0] r);
    if (exmem_we && exmem_rd != 0 && exmem_rd == r) return 2'b10;
    if (memwb_we && memwb_rd != 0 && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction
  // Returns {load_use_stall_cycle, fwd_a, fwd_b, stall_if..stall_mem, flush_id..flush_wb, pc_redirect}
  function automatic logic [12:0] model(input bit pend);
    bit mb, ib, lu, lu_cyc, si, sid, sex, smem, fid, fex, fwb, pc;
    mb = mem_req && !mem_ack;
    ib = if_req && !if_ack;
    lu = idex_mr && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    {lu_cyc, si, sid, sex, smem, fid, fex, fwb, pc} = '0;
    if (pend) begin
      fid = 1; si = ib;
      if (mb) {si, sid, sex, smem, fwb} = 5'b11111;
    end else if (mb) {si, sid, sex, smem, fwb} = 5'b11111;
    else if (br) {pc, fid, fex} = 3'b111;
    else if (lu) {si, sid, fex, lu_cyc} = 4'b1111;
    else if (ib) {si, fid} = 2'b11;
    if (fid) sid = 0;
    if (fex) sex = 0;
    return {lu_cyc, fwd_of(idex_rs1), fwd_of(idex_rs2), si, sid, sex, smem, fid, fex, fwb, pc};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step(input string tag);
    logic [12:0] e;
    @(negedge clk);
    e = model(pend_m);
    chk(tag, {20'd0, obs()}, {20'd0, e[11:0]});
    m_stall += int'(e[7]);
    m_flush += int'(e[0]);
    m_lu    += int'(e[12]);
    pend_m = pend_m ? !if_ack : (!(mem_req && !mem_ack) && br && if_req && !if_ack);
    @(posedge clk);
    #1;
  endtask
  task automatic zero_inputs();
    {ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {idex_mr, exmem_we, memwb_we, br, if_req, if_ack, mem_req, mem_ack} = '0;
  endtask
  initial begin
    zero_inputs();
    #1;
    chk("reset_outputs", {20'd0, obs()}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    step("idle");
    idex_rs1 = 5; exmem_rd = 5; exmem_we = 1; memwb_rd = 5; memwb_we = 1; #1;
    chk("fwd_exmem", {30'd0, fwd_a}, 32'd2);
    step("fwd_exmem_v");
    exmem_we = 0; #1;
    chk("fwd_memwb", {30'd0, fwd_a}, 32'd1);
    step("fwd_memwb_v");
    exmem_we = 1; exmem_rd = 0; memwb_rd = 0; #1;
    chk("fwd_rd0", {30'd0, fwd_a}, 32'd0);
    step("fwd_rd0_v");
    zero_inputs();
    idex_mr = 1; idex_rd = 7; ifid_rs2 = 7; #1;
    chk("load_use", {29'd0, s_if, s_id, f_ex}, 32'd7);
    step("load_use_v");
    idex_mr = 0; idex_rd = 0;
    step("load_use_done");
    zero_inputs();
    mem_req = 1; br = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mem_busy_br", {27'd0, s_if, s_id, s_ex, s_mem, f_wb, pcr}, 32'b111110);
      step("mem_busy_v");
    end
    mem_ack = 1; #1;
    chk("mem_ack_br", {29'd0, pcr, f_id, f_ex}, 32'd7);
    step("mem_ack_v");
    zero_inputs();
    br = 1; if_req = 1; #1;
    chk("br_ifbusy", {30'd0, pcr, f_id}, 32'd3);
    step("br_ifbusy_v");
    br = 0;
    step("br_pend1");
    #1;
    chk("br_pend_hold", {29'd0, pcr, f_id, s_if}, 32'd3);
    step("br_pend2");
    if_ack = 1; #1;
    chk("br_pend_ack", {30'd0, f_id, s_if}, 32'd2);
    step("br_pend_ack_v");
    zero_inputs();
    step("back_to_run");
    br = 1; if_req = 1;
    step("br_enter_again");
    zero_inputs(); #1;
    chk("pend_idle_flush", {31'd0, f_id}, 32'd1);
    rst = 1; #1;
    chk("async_reset", {20'd0, obs()}, 32'd0);
    pend_m = 0; m_stall = 0; m_flush = 0; m_lu = 0;
    @(posedge clk); #1;
    rst = 0;
    step("after_reset");
    for (int n = 0; n < 400; n++) begin
      ifid_rs1 = 5'($urandom_range(0, 3)); ifid_rs2 = 5'($urandom_range(0, 3));
      idex_rs1 = 5'($urandom_range(0, 3)); idex_rs2 = 5'($urandom_range(0, 3));
      idex_rd  = 5'($urandom_range(0, 3)); exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      idex_mr = 1'($urandom_range(0, 1)); exmem_we = 1'($urandom_range(0, 1));
      memwb_we = 1'($urandom_range(0, 1)); br = ($urandom_range(0, 3) == 0);
      if_req = 1'($urandom_range(0, 1)); if_ack = ($urandom_range(0, 2) == 0);
      mem_req = ($urandom_range(0, 2) == 0); mem_ack = 1'($urandom_range(0, 1));
      step("random");
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", p_stall, 32'(m_stall));
    chk("perf_flush", p_flush, 32'(m_flush));
    chk("perf_lu", p_lu, 32'(m_lu));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
